cam_pwr_seq: RTL and testbench

CAM_PWR_SEQ -- requirements
Module: cam_pwr_seq

---
 rtl/cam_pwr_seq.sv | 157 +++++++++++++++
 tb/tb_cam_pwr_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pwr_seq.sv
// ---------------------------------------------------------------------------
// cam_pwr_seq -- camera power-up sequencer
//
// Walks an image sensor through power-down, reset and settle intervals, then
// launches SCCB configuration and waits for the configurator to finish.
//
// Optional feature macro: CAM_SEQ_TIMEOUT_EN
//   When defined, the CFG wait is bounded by T_CFG_TO_CYC cycles. A timeout
//   sets the sticky cfg_err flag and automatically re-runs the sequence.
//   When undefined, CFG waits forever and cfg_err is a constant 0.
//
// Ports
//   clk       in   12 MHz PLL clock, the only clock
//   reset     in   synchronous, active-high reset
//   restart   in   request a full re-sequence (accepted only in READY)
//   cfg_done  in   one-cycle completion pulse from the SCCB configurator
//   cam_pwdn  out  camera power-down pin, active-high
//   cam_rst_n out  camera reset pin, active-low
//   cfg_start out  one-cycle pulse launching SCCB configuration
//   busy      out  high in every state except READY
//   ready     out  high only in READY
//   cfg_err   out  sticky configuration-timeout flag
// ---------------------------------------------------------------------------
module cam_pwr_seq #(
   parameter int T_PWDN_CYC   = 4,
   parameter int T_RST_CYC    = 3,
   parameter int T_SETTLE_CYC = 5,
   parameter int T_CFG_TO_CYC = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic cfg_done,
   output logic cam_pwdn,
   output logic cam_rst_n,
   output logic cfg_start,
   output logic busy,
   output logic ready,
   output logic cfg_err
);

   // Counter reload values: a timed state of length T starts at T-1 and
   // leaves on the edge that sees 0, giving exactly T cycles.
   localparam logic [23:0] PWDN_LD   = 24'(T_PWDN_CYC - 1);
   localparam logic [23:0] RST_LD    = 24'(T_RST_CYC - 1);
   localparam logic [23:0] SETTLE_LD = 24'(T_SETTLE_CYC - 1);
   // Without the timeout the counter is simply parked at this value in CFG.
   localparam logic [23:0] CFG_LD    = 24'(T_CFG_TO_CYC - 1);

   typedef enum logic [2:0] {
      S_PWDN,
      S_RST,
      S_SETTLE,
      S_CFG,
      S_READY
   } state_t;

   state_t      state;
   logic [23:0] cnt;

`ifdef CAM_SEQ_TIMEOUT_EN
   logic err_q;
   assign cfg_err = err_q;
`else
   assign cfg_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_PWDN;
         cnt       <= PWDN_LD;
         cam_pwdn  <= 1'b1;
         cam_rst_n <= 1'b0;
         cfg_start <= 1'b0;
         ready     <= 1'b0;
         busy      <= 1'b1;
`ifdef CAM_SEQ_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         // cfg_start is a single-cycle pulse; only the SETTLE exit raises it.
         cfg_start <= 1'b0;
         case (state)
            S_PWDN: begin
               if (cnt == 24'd0) begin
                  state     <= S_RST;
                  cnt       <= RST_LD;
                  cam_pwdn  <= 1'b0;
                  cam_rst_n <= 1'b0;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            S_RST: begin
               if (cnt == 24'd0) begin
                  state     <= S_SETTLE;
                  cnt       <= SETTLE_LD;
                  cam_rst_n <= 1'b1;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            S_SETTLE: begin
               if (cnt == 24'd0) begin
                  state     <= S_CFG;
                  cnt       <= CFG_LD;
                  cfg_start <= 1'b1;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            S_CFG: begin
               // cfg_done is checked first so it beats a coincident timeout,
               // and it is honoured even in the cfg_start cycle.
               if (cfg_done) begin
                  state <= S_READY;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end
`ifdef CAM_SEQ_TIMEOUT_EN
               else if (cnt == 24'd0) begin
                  state     <= S_PWDN;
                  cnt       <= PWDN_LD;
                  cam_pwdn  <= 1'b1;
                  cam_rst_n <= 1'b0;
                  err_q     <= 1'b1;
               end else begin
                  cnt <= cnt - 24'd1;
               end
`endif
            end
            S_READY: begin
               if (restart) begin
                  state     <= S_PWDN;
                  cnt       <= PWDN_LD;
                  cam_pwdn  <= 1'b1;
                  cam_rst_n <= 1'b0;
                  ready     <= 1'b0;
                  busy      <= 1'b1;
`ifdef CAM_SEQ_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
               end
            end
            default: begin
               state     <= S_PWDN;
               cnt       <= PWDN_LD;
               cam_pwdn  <= 1'b1;
               cam_rst_n <= 1'b0;
               ready     <= 1'b0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_cam_pwr_seq -- self-checking bench for cam_pwr_seq.
// Cycle k is the clock period ending at the k-th edge after reset release;
// the outputs seen during cycle k are checked on its falling edge, and the
// inputs applied in cycle k are sampled by the edge that closes it.
// The reference model tracks the position inside the power-up timeline.
// ---------------------------------------------------------------------------
module tb_cam_pwr_seq;

   localparam int TP = 4;
   localparam int TR = 3;
   localparam int TS = 5;
   localparam int TO = 10;
   localparam int CFG_POS = TP + TR + TS + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic restart = 1'b0;
   logic cfg_done = 1'b0;
   logic cam_pwdn, cam_rst_n, cfg_start, busy, ready, cfg_err;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: position within the sequence, ready and error flags.
   int pos = 1;
   bit mrdy = 1'b0;
   bit merr = 1'b0;

   cam_pwr_seq #(
      .T_PWDN_CYC(TP), .T_RST_CYC(TR), .T_SETTLE_CYC(TS), .T_CFG_TO_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .restart(restart), .cfg_done(cfg_done),
      .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .cfg_start(cfg_start),
      .busy(busy), .ready(ready), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   function automatic void model_update(input bit r, input bit rs, input bit cd);
      if (r) begin
         pos = 1; mrdy = 1'b0; merr = 1'b0;
      end else if (mrdy) begin
         if (rs) begin
            pos = 1; mrdy = 1'b0; merr = 1'b0;
         end
      end else if (pos >= CFG_POS) begin
         if (cd) mrdy = 1'b1;
`ifdef CAM_SEQ_TIMEOUT_EN
         else if (pos == CFG_POS + TO - 1) begin
            merr = 1'b1; pos = 1;
         end
`endif
         else pos = pos + 1;
      end else begin
         pos = pos + 1;
      end
   endfunction

   // {cam_pwdn, cam_rst_n, cfg_start, busy, ready, cfg_err}
   function automatic logic [5:0] model_out();
      if (mrdy)              return {5'b01001, merr};
      else if (pos <= TP)    return {5'b10010, merr};
      else if (pos <= TP+TR) return {5'b00010, merr};
      else                   return {2'b01, (pos == CFG_POS), 2'b10, merr};
   endfunction

   function automatic logic [5:0] obs();
      return {cam_pwdn, cam_rst_n, cfg_start, busy, ready, cfg_err};
   endfunction

   // Close the current cycle, update the model with what the DUT sampled,
   // apply the next cycle's inputs and stop on its falling edge.
   task automatic tick(input logic r, input logic rs, input logic cd);
      @(posedge clk);
      model_update(reset, restart, cfg_done);
      #1;
      reset = r; restart = rs; cfg_done = cd;
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, i[0], 1'b1);
         n_checks++;
         if (obs() !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_values cycle %0d: got %b want %b", i, obs(), 6'b100100);
         end
      end
   endtask

   task automatic test_release();
      tick(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         tick(1'b0, 1'b0, c == 14);
         n_checks++;
         if (obs() !== model_out()) begin
            n_fail++;
            $display("FAIL release_model cycle %0d: got %b want %b", c, obs(), model_out());
         end
         n_checks++;
         if (cam_pwdn !== (c <= 4) || cam_rst_n !== (c >= 8) ||
             cfg_start !== (c == 13) || ready !== (c >= 15)) begin
            n_fail++;
            $display("FAIL release_timeline cycle %0d: got pwdn=%b rst_n=%b start=%b ready=%b want %b %b %b %b",
                     c, cam_pwdn, cam_rst_n, cfg_start, ready, c <= 4, c >= 8, c == 13, c >= 15);
         end
      end
   endtask

   task automatic test_done_held();
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      for (int c = 1; c <= 16; c++) begin
         tick(1'b0, 1'b0, 1'b1);
         n_checks++;
         if (obs() !== model_out() || ready !== (c >= 14) || cfg_start !== (c == 13)) begin
            n_fail++;
            $display("FAIL done_held cycle %0d: got %b want %b (ready %b start %b)",
                     c, obs(), model_out(), c >= 14, c == 13);
         end
      end
   endtask

   task automatic test_restart();
      int starts;
      starts = 0;
      tick(1'b0, 1'b1, 1'b0);
      // restart in cycle 6 falls in RST and must be ignored
      for (int j = 1; j <= 16; j++) begin
         tick(1'b0, j == 6, j == 14);
         if (cfg_start === 1'b1) starts++;
         n_checks++;
         if (obs() !== model_out() || cam_pwdn !== (j <= 4) || cfg_start !== (j == 13) ||
             ready !== (j >= 15)) begin
            n_fail++;
            $display("FAIL restart cycle %0d: got %b want %b (pwdn %b start %b ready %b)",
                     j, obs(), model_out(), j <= 4, j == 13, j >= 15);
         end
      end
      n_checks++;
      if (starts != 1) begin
         n_fail++;
         $display("FAIL restart_cfg_start_count: got %0d want 1", starts);
      end
   endtask

   task automatic test_reset_mid_cfg();
      tick(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 12; c++) tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (cfg_start !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_cfg_entry: got start=%b busy=%b want 1 1", cfg_start, busy);
      end
      tick(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== 6'b100100) begin
         n_fail++;
         $display("FAIL mid_cfg_abort: got %b want %b", obs(), 6'b100100);
      end
      for (int c = 1; c <= 14; c++) begin
         tick(1'b0, 1'b0, 1'b0);
         n_checks++;
         if (obs() !== model_out() || cam_pwdn !== (c <= 4) || cfg_start !== (c == 13)) begin
            n_fail++;
            $display("FAIL mid_cfg_rerun cycle %0d: got %b want %b", c, obs(), model_out());
         end
      end
   endtask

`ifdef CAM_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      tick(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 42; c++) begin
         tick(1'b0, c == 40, c == 36);
         n_checks++;
         if (obs() !== model_out() || cfg_err !== (c >= 23 && c <= 40) ||
             cfg_start !== (c == 13 || c == 35) || ready !== (c >= 37 && c <= 40) ||
             (c == 23 && (cam_pwdn !== 1'b1 || cam_rst_n !== 1'b0))) begin
            n_fail++;
            $display("FAIL timeout cycle %0d: got %b want %b", c, obs(), model_out());
         end
      end
   endtask

   task automatic test_timeout_last();
      tick(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 24; c++) begin
         tick(1'b0, 1'b0, c == 22);
         n_checks++;
         if (obs() !== model_out() || ready !== (c >= 23) || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_last cycle %0d: got %b want %b", c, obs(), model_out());
         end
      end
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      bad = 0;
      tick(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 1012; c++) begin
         tick(1'b0, 1'b0, 1'b0);
         if (cfg_err !== 1'b0 || (c >= 13 && (ready !== 1'b0 || cam_rst_n !== 1'b1)))
            bad++;
      end
      n_checks++;
      if (bad != 0 || busy !== 1'b1 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout: got %0d bad cycles busy=%b err=%b want 0 1 0", bad, busy, cfg_err);
      end
   endtask
`endif

   task automatic test_random();
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 9) == 0);
         n_checks++;
         if (obs() !== model_out()) begin
            n_fail++;
            $display("FAIL random step %0d: got %b want %b", i, obs(), model_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_done_held();
      test_restart();
      test_reset_mid_cfg();
`ifdef CAM_SEQ_TIMEOUT_EN
      test_timeout();
      test_timeout_last();
`else
      test_no_timeout();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
